dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 32, word width of data memory and both requester ports.
REQ-002 Parameter ADDR_WIDTH, default 10, byte address width.
REQ-003 Parameter MAX_LOCK, default 8, maximum consecutive locked grants; range 2..255.
REQ-004 Port clk  in  1  single clock, all state on rising edge.
REQ-005 Port rstn  in  1  reset, asynchronous assert, active-low.
REQ-006 Ports m0_req / m1_req  in  1  access request; held high until granted.
REQ-007 Ports m0_we / m1_we  in  1  1 = write, 0 = read.
REQ-008 Ports m0_addr / m1_addr  in  ADDR_WIDTH  byte address.
REQ-009 Ports m0_byteEn / m1_byteEn  in  DATA_WIDTH/8  write byte enables.
REQ-010 Ports m0_wdata / m1_wdata  in  DATA_WIDTH  write data.
REQ-011 Ports m0_lock / m1_lock  in  1  burst hold request; ignored unless DMEM_ARB_LOCK_EN is defined.
REQ-012 Ports m0_gnt / m1_gnt  out  1  access accepted this cycle.
REQ-013 Ports m0_rvalid / m1_rvalid  out  1  read data valid this cycle.
REQ-014 Ports m0_rdata / m1_rdata  out  DATA_WIDTH  read data.
REQ-015 Ports mem_en, mem_we  out  1  memory enable, write strobe.
REQ-016 Ports mem_addr  out  ADDR_WIDTH; mem_byteEn  out  DATA_WIDTH/8; mem_wdata  out  DATA_WIDTH  memory command.
REQ-017 Port mem_rdata  in  DATA_WIDTH  memory read data, valid one cycle after the read command (registered read).

Function
REQ-018 At most one gnt per cycle; gnt is combinational from req and arbiter state, same cycle as the memory command.
REQ-019 mem_en = m0_gnt | m1_gnt; mem_we, mem_addr, mem_byteEn, mem_wdata mux from the granted requester; all memory command outputs zero when no grant.
REQ-020 Single requester: granted in the same cycle it asserts req.
REQ-021 Both requesting: winner is the requester not recorded in register lastGnt; lastGnt updates to the winner on every grant.
REQ-022 Consequence: under continuous contention grants alternate; no requester waits more than 1 cycle.
REQ-023 Granted read: registered rdOwner/rdPend capture owner; next cycle that requester's rvalid = 1 and its rdata = mem_rdata.
REQ-024 Non-owner rdata is all zeros; rvalid never asserted for writes.
REQ-025 Back-to-back reads from alternating requesters: each rvalid/rdata pair routes to its own issuer with 1-cycle latency, no bubbles.
REQ-026 Simultaneous read-return and new grant in the same cycle are independent; both proceed.

Reset
REQ-027 While rstn = 0: lastGnt = 1 (m0 wins first tie), rdPend = 0, lock counter = 0, lock owner cleared.
REQ-028 While rstn = 0 all gnt, rvalid and memory command outputs are 0 and rdata outputs are zero.
REQ-029 A read granted the cycle before reset assertion produces no rvalid after reset release.

Configuration
REQ-030 Macro DMEM_ARB_LOCK_EN defined: granted requester with req & lock keeps priority on following cycles regardless of lastGnt.
REQ-031 Lock counter counts consecutive locked grants; once the count reaches MAX_LOCK with the other requester pending, the other requester wins the next cycle and the counter clears.
REQ-032 Lock releases when the owner deasserts lock or req; the counter clears and round-robin resumes.
REQ-033 Macro DMEM_ARB_LOCK_EN undefined: lock inputs unused; no lock counter logic; pure round-robin per REQ-021.

Verification
REQ-034 Only m0 reads addr 0x010 with mem_rdata = 0xDEADBEEF next cycle -> m0_gnt same cycle, m0_rvalid = 1 and m0_rdata = 0xDEADBEEF one cycle later, m1 outputs zero.
REQ-035 Both req held 6 cycles after reset -> grant order m0,m1,m0,m1,m0,m1.
REQ-036 m1 write addr 0x020, data 0x12345678, byteEn 0x3 -> mem_en = 1, mem_we = 1, mem_addr = 0x020, mem_byteEn = 0x3, mem_wdata = 0x12345678 same cycle, no rvalid.
REQ-037 rstn pulsed low the cycle after an m0 read grant -> no m0_rvalid; the first tie after release goes to m0.
REQ-038 DMEM_ARB_LOCK_EN, MAX_LOCK = 4, m0 req+lock, m1 req continuous -> m0 granted 4 cycles, m1 granted cycle 5, m0 resumes cycle 6.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// Requester-side bundle for the data-memory arbiter.
// One instance per requester: the requester drives the command half
// (req/we/addr/byteEn/wdata/lock) and receives grant and read return.
interface dmem_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
);
  logic                    req;
  logic                    we;
  logic [ADDR_WIDTH-1:0]   addr;
  logic [DATA_WIDTH/8-1:0] byteEn;
  logic [DATA_WIDTH-1:0]   wdata;
  logic                    lock;
  logic                    gnt;
  logic                    rvalid;
  logic [DATA_WIDTH-1:0]   rdata;

  modport master (
    output req, we, addr, byteEn, wdata, lock,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, byteEn, wdata, lock,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port data memory
// with a registered (one-cycle) read.
// Optional burst locking is compiled in when DMEM_ARB_LOCK_EN is defined:
// a granted requester holding lock keeps priority for up to MAX_LOCK
// consecutive grants while the other side is waiting.
module dmem_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int MAX_LOCK   = 8
) (
  input  logic                    clk,
  input  logic                    rstn,
  dmem_arbiter_if.slave           m0,
  dmem_arbiter_if.slave           m1,
  output logic                    mem_en,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH/8-1:0] mem_byteEn,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  input  logic [DATA_WIDTH-1:0]   mem_rdata
);

  // lastGnt: 0 = m0 was granted last, 1 = m1 was granted last
  logic lastGnt_q, lastGnt_d;
  logic rdPend_q, rdPend_d;
  logic rdOwner_q, rdOwner_d;

  logic gnt0, gnt1;
  logic pick1;

`ifdef DMEM_ARB_LOCK_EN
  logic       lockActive_q, lockActive_d;
  logic       lockOwner_q, lockOwner_d;
  logic [7:0] lockCnt_q, lockCnt_d;
  logic       lockHeld, lockYield;
  logic       winLock;

  // Tie-break choice: a live lock wins unless its budget is spent and the other side waits
  always_comb begin
    lockHeld  = lockActive_q &&
                (lockOwner_q ? (m1.req && m1.lock) : (m0.req && m0.lock));
    lockYield = lockHeld && (lockCnt_q >= 8'(MAX_LOCK)) &&
                (lockOwner_q ? m0.req : m1.req);
    if (lockYield)
      pick1 = ~lockOwner_q;
    else if (lockHeld)
      pick1 = lockOwner_q;
    else
      pick1 = ~lastGnt_q;
  end

  // Lock tracking: count consecutive locked grants to the same owner
  always_comb begin
    lockActive_d = 1'b0;
    lockOwner_d  = lockOwner_q;
    lockCnt_d    = 8'd0;
    winLock      = gnt1 ? m1.lock : m0.lock;
    if ((gnt0 || gnt1) && winLock) begin
      lockActive_d = 1'b1;
      lockOwner_d  = gnt1;
      if (lockHeld && !lockYield && (gnt1 == lockOwner_q))
        lockCnt_d = (lockCnt_q == 8'd255) ? lockCnt_q : lockCnt_q + 8'd1;
      else
        lockCnt_d = 8'd1;
    end
  end

  // Lock state registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      lockActive_q <= 1'b0;
      lockOwner_q  <= 1'b0;
      lockCnt_q    <= 8'd0;
    end else begin
      lockActive_q <= lockActive_d;
      lockOwner_q  <= lockOwner_d;
      lockCnt_q    <= lockCnt_d;
    end
  end
`else
  logic lockUnused;
  assign lockUnused = m0.lock | m1.lock;

  // Plain round-robin: on a tie the side not granted last wins
  always_comb begin
    pick1 = ~lastGnt_q;
  end
`endif

  // Grant decode; gated by reset so nothing is issued while rstn is low
  always_comb begin
    gnt0 = rstn && m0.req && (!m1.req || !pick1);
    gnt1 = rstn && m1.req && (!m0.req ||  pick1);
  end

  assign m0.gnt = gnt0;
  assign m1.gnt = gnt1;

  // Memory command mux; all fields forced to zero without a grant
  always_comb begin
    mem_en     = gnt0 | gnt1;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_byteEn = '0;
    mem_wdata  = '0;
    if (gnt0) begin
      mem_we     = m0.we;
      mem_addr   = m0.addr;
      mem_byteEn = m0.byteEn;
      mem_wdata  = m0.wdata;
    end else if (gnt1) begin
      mem_we     = m1.we;
      mem_addr   = m1.addr;
      mem_byteEn = m1.byteEn;
      mem_wdata  = m1.wdata;
    end
  end

  // Read return routing: only the recorded owner sees valid data
  always_comb begin
    m0.rvalid = rdPend_q && !rdOwner_q;
    m1.rvalid = rdPend_q &&  rdOwner_q;
    m0.rdata  = m0.rvalid ? mem_rdata : '0;
    m1.rdata  = m1.rvalid ? mem_rdata : '0;
  end

  // Next-state for round-robin history and the pending read tag
  always_comb begin
    lastGnt_d = lastGnt_q;
    rdOwner_d = rdOwner_q;
    if (gnt1) begin
      lastGnt_d = 1'b1;
      rdOwner_d = 1'b1;
    end else if (gnt0) begin
      lastGnt_d = 1'b0;
      rdOwner_d = 1'b0;
    end
    rdPend_d = (gnt0 && !m0.we) || (gnt1 && !m1.we);
  end

  // Arbiter state registers; reset leaves m0 winning the first tie
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      lastGnt_q <= 1'b1;
      rdPend_q  <= 1'b0;
      rdOwner_q <= 1'b0;
    end else begin
      lastGnt_q <= lastGnt_d;
      rdPend_q  <= rdPend_d;
      rdOwner_q <= rdOwner_d;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: reset behaviour, round-robin order,
// read return routing, write command muxing, reset during a pending read,
// and (when DMEM_ARB_LOCK_EN is defined) the lock budget.
module tb_dmem_arbiter;
  localparam int DW = 32;
  localparam int AW = 10;

  logic          clk;
  logic          rstn;
  logic          memEn;
  logic          memWe;
  logic [AW-1:0] memAddr;
  logic [DW/8-1:0] memByteEn;
  logic [DW-1:0] memWdata;
  logic [DW-1:0] memRdata;

  int checks = 0;
  int errors = 0;

  dmem_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) m0If ();
  dmem_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) m1If ();

  dmem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_LOCK(4)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .m0         (m0If),
    .m1         (m1If),
    .mem_en     (memEn),
    .mem_we     (memWe),
    .mem_addr   (memAddr),
    .mem_byteEn (memByteEn),
    .mem_wdata  (memWdata),
    .mem_rdata  (memRdata)
  );

  // Free-running clock, first rising edge at t=5
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive one requester's command fields
  task automatic applyStimulus(input int port, input logic req, input logic we,
                               input logic [AW-1:0] addr, input logic [DW/8-1:0] be,
                               input logic [DW-1:0] wd, input logic lock);
    if (port == 0) begin
      m0If.req = req; m0If.we = we; m0If.addr = addr;
      m0If.byteEn = be; m0If.wdata = wd; m0If.lock = lock;
    end else begin
      m1If.req = req; m1If.we = we; m1If.addr = addr;
      m1If.byteEn = be; m1If.wdata = wd; m1If.lock = lock;
    end
  endtask

  // One comparison point
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rstn     = 1'b0;
    memRdata = 32'hFFFF_FFFF;
    applyStimulus(0, 1'b1, 1'b0, 10'h100, 4'hF, 32'h0, 1'b0);
    applyStimulus(1, 1'b1, 1'b0, 10'h200, 4'hF, 32'h0, 1'b0);

    // Reset: requests are present but nothing may be granted or returned
    #3;
    checkOutput("rst_m0_gnt",   m0If.gnt,    1'b0);
    checkOutput("rst_m1_gnt",   m1If.gnt,    1'b0);
    checkOutput("rst_mem_en",   memEn,       1'b0);
    checkOutput("rst_mem_addr", memAddr,     10'h0);
    checkOutput("rst_m0_rv",    m0If.rvalid, 1'b0);
    checkOutput("rst_m0_rdata", m0If.rdata,  32'h0);
    checkOutput("rst_m1_rdata", m1If.rdata,  32'h0);

    // Continuous contention: grants alternate starting with m0,
    // each read returns to its own issuer one cycle later
    nextCycle();
    rstn = 1'b1;
    for (int k = 0; k < 6; k++) begin
      memRdata = 32'hA000_0000 + k;
      #2;
      checkOutput($sformatf("rr_m0_gnt_%0d", k), m0If.gnt, (k % 2 == 0));
      checkOutput($sformatf("rr_m1_gnt_%0d", k), m1If.gnt, (k % 2 == 1));
      checkOutput($sformatf("rr_addr_%0d", k), memAddr, (k % 2 == 0) ? 10'h100 : 10'h200);
      if (k > 0) begin
        checkOutput($sformatf("rr_m0_rv_%0d", k), m0If.rvalid, (k % 2 == 1));
        checkOutput($sformatf("rr_m1_rv_%0d", k), m1If.rvalid, (k % 2 == 0));
        checkOutput($sformatf("rr_rdata_%0d", k),
                    (k % 2 == 1) ? m0If.rdata : m1If.rdata, 32'hA000_0000 + k);
      end
      nextCycle();
    end
    applyStimulus(0, 1'b0, 1'b0, 10'h0, 4'h0, 32'h0, 1'b0);
    applyStimulus(1, 1'b0, 1'b0, 10'h0, 4'h0, 32'h0, 1'b0);
    memRdata = 32'hA000_0006;
    #2;
    checkOutput("rr_last_m1_rv",    m1If.rvalid, 1'b1);
    checkOutput("rr_last_m1_rdata", m1If.rdata,  32'hA000_0006);
    checkOutput("rr_last_m0_rv",    m0If.rvalid, 1'b0);
    checkOutput("idle_mem_en",      memEn,       1'b0);

    // Single m0 read of 0x010
    nextCycle();
    applyStimulus(0, 1'b1, 1'b0, 10'h010, 4'hF, 32'h0, 1'b0);
    memRdata = 32'h0BAD_F00D;
    #2;
    checkOutput("rd_m0_gnt",  m0If.gnt, 1'b1);
    checkOutput("rd_m1_gnt",  m1If.gnt, 1'b0);
    checkOutput("rd_mem_en",  memEn,    1'b1);
    checkOutput("rd_mem_we",  memWe,    1'b0);
    checkOutput("rd_mem_addr", memAddr, 10'h010);
    nextCycle();
    applyStimulus(0, 1'b0, 1'b0, 10'h0, 4'h0, 32'h0, 1'b0);
    memRdata = 32'hDEAD_BEEF;
    #2;
    checkOutput("rd_m0_rv",    m0If.rvalid, 1'b1);
    checkOutput("rd_m0_rdata", m0If.rdata,  32'hDEAD_BEEF);
    checkOutput("rd_m1_rv",    m1If.rvalid, 1'b0);
    checkOutput("rd_m1_rdata", m1If.rdata,  32'h0);
    checkOutput("rd_m1_gnt",   m1If.gnt,    1'b0);

    // m1 write; m0 fields carry distinct junk so the mux is exercised
    nextCycle();
    applyStimulus(0, 1'b0, 1'b1, 10'h3FC, 4'hF, 32'hFFFF_FFFF, 1'b0);
    applyStimulus(1, 1'b1, 1'b1, 10'h020, 4'h3, 32'h1234_5678, 1'b0);
    #2;
    checkOutput("wr_m1_gnt",  m1If.gnt,   1'b1);
    checkOutput("wr_mem_en",  memEn,      1'b1);
    checkOutput("wr_mem_we",  memWe,      1'b1);
    checkOutput("wr_addr",    memAddr,    10'h020);
    checkOutput("wr_byteEn",  memByteEn,  4'h3);
    checkOutput("wr_wdata",   memWdata,   32'h1234_5678);

    // m1 again alone right after its own grant: still granted at once
    nextCycle();
    applyStimulus(1, 1'b1, 1'b0, 10'h024, 4'hF, 32'h0, 1'b0);
    #2;
    checkOutput("wr_no_m1_rv", m1If.rvalid, 1'b0);
    checkOutput("wr_no_m0_rv", m0If.rvalid, 1'b0);
    checkOutput("rep_m1_gnt",  m1If.gnt,    1'b1);
    checkOutput("rep_mem_we",  memWe,       1'b0);

    // Read return for m1 overlaps a new m0 read grant
    nextCycle();
    applyStimulus(1, 1'b0, 1'b0, 10'h0, 4'h0, 32'h0, 1'b0);
    applyStimulus(0, 1'b1, 1'b0, 10'h030, 4'hF, 32'h0, 1'b0);
    memRdata = 32'h55AA_55AA;
    #2;
    checkOutput("ovl_m0_gnt",   m0If.gnt,    1'b1);
    checkOutput("ovl_addr",     memAddr,     10'h030);
    checkOutput("ovl_m1_rv",    m1If.rvalid, 1'b1);
    checkOutput("ovl_m1_rdata", m1If.rdata,  32'h55AA_55AA);
    checkOutput("ovl_m0_rv",    m0If.rvalid, 1'b0);
    checkOutput("ovl_m0_rdata", m0If.rdata,  32'h0);
    nextCycle();
    applyStimulus(0, 1'b0, 1'b0, 10'h0, 4'h0, 32'h0, 1'b0);
    memRdata = 32'h1357_9BDF;
    #2;
    checkOutput("ovl2_m0_rv",    m0If.rvalid, 1'b1);
    checkOutput("ovl2_m0_rdata", m0If.rdata,  32'h1357_9BDF);

    // Reset right after an m0 read grant: the read must be dropped
    nextCycle();
    applyStimulus(0, 1'b1, 1'b0, 10'h040, 4'hF, 32'h0, 1'b0);
    #2;
    checkOutput("rr_pre_m0_gnt", m0If.gnt, 1'b1);
    nextCycle();
    rstn = 1'b0;
    applyStimulus(0, 1'b0, 1'b0, 10'h0, 4'h0, 32'h0, 1'b0);
    #2;
    checkOutput("rstp_m0_rv",    m0If.rvalid, 1'b0);
    checkOutput("rstp_m0_rdata", m0If.rdata,  32'h0);
    nextCycle();
    rstn = 1'b1;
    #2;
    checkOutput("rstp_post_rv", m0If.rvalid, 1'b0);
    nextCycle();
    applyStimulus(0, 1'b1, 1'b0, 10'h044, 4'hF, 32'h0, 1'b0);
    applyStimulus(1, 1'b1, 1'b0, 10'h048, 4'hF, 32'h0, 1'b0);
    #2;
    checkOutput("rstp_tie_m0", m0If.gnt, 1'b1);
    checkOutput("rstp_tie_m1", m1If.gnt, 1'b0);

`ifdef DMEM_ARB_LOCK_EN
    // Lock budget of 4: m0 x4, forced m1, then m0 again
    nextCycle();
    rstn = 1'b0;
    applyStimulus(0, 1'b0, 1'b0, 10'h0, 4'h0, 32'h0, 1'b0);
    applyStimulus(1, 1'b0, 1'b0, 10'h0, 4'h0, 32'h0, 1'b0);
    nextCycle();
    rstn = 1'b1;
    applyStimulus(0, 1'b1, 1'b1, 10'h050, 4'hF, 32'h0, 1'b1);
    applyStimulus(1, 1'b1, 1'b1, 10'h060, 4'hF, 32'h0, 1'b0);
    for (int k = 0; k < 6; k++) begin
      #2;
      checkOutput($sformatf("lock_m0_gnt_%0d", k), m0If.gnt, (k != 4));
      checkOutput($sformatf("lock_m1_gnt_%0d", k), m1If.gnt, (k == 4));
      nextCycle();
    end
    applyStimulus(0, 1'b0, 1'b0, 10'h0, 4'h0, 32'h0, 1'b0);
    applyStimulus(1, 1'b0, 1'b0, 10'h0, 4'h0, 32'h0, 1'b0);
`endif

    nextCycle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
